ysyx_22040237_wb_queue: RTL and testbench

//  Register-file write side for the NPC core. Collects results from EXU and LSU over

---
 rtl/ysyx_22040237_pkg.sv | 11 +
 rtl/ysyx_22040237_wb_sb.sv | 38 +++
 rtl/ysyx_22040237_wb_queue.sv | 118 +++++++++++
 tb/tb_ysyx_22040237_wb_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040237_pkg.sv
// rtl/ysyx_22040237_pkg.sv - shared GPR constants and write-back queue entry type
package ysyx_22040237_pkg;
  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;
  localparam int REG_WIDTH = 64;

  typedef struct packed {
    logic [4:0]           rd;
    logic [REG_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/ysyx_22040237_wb_sb.sv
// rtl/ysyx_22040237_wb_sb.sv - per-GPR pending-write counters with two busy query ports
module ysyx_22040237_wb_sb
  import ysyx_22040237_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc0_en,
  input  logic [REG_IDX_W-1:0] inc0_idx,
  input  logic                 inc1_en,
  input  logic [REG_IDX_W-1:0] inc1_idx,
  input  logic                 dec_en,
  input  logic [REG_IDX_W-1:0] dec_idx,
  input  logic [REG_IDX_W-1:0] q0_idx,
  input  logic [REG_IDX_W-1:0] q1_idx,
  output logic                 q0_busy,
  output logic                 q1_busy
);
  logic [CNT_W-1:0] cnt [REG_NUM];

  // Same-cycle increments and decrement on one GPR resolve to their net change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        cnt[i] <= cnt[i]
                + CNT_W'(inc0_en && (inc0_idx == REG_IDX_W'(i)))
                + CNT_W'(inc1_en && (inc1_idx == REG_IDX_W'(i)))
                - CNT_W'(dec_en  && (dec_idx  == REG_IDX_W'(i)));
      end
    end
  end

  assign q0_busy = (q0_idx != '0) && (cnt[q0_idx] != '0);
  assign q1_busy = (q1_idx != '0) && (cnt[q1_idx] != '0);
endmodule

// File: rtl/ysyx_22040237_wb_queue.sv
// rtl/ysyx_22040237_wb_queue.sv - in-order GPR write-back queue with RAW scoreboard
// Optional youngest-entry bypass search: YSYX_22040237_WB_BYPASS_EN.
module ysyx_22040237_wb_queue
  import ysyx_22040237_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int REG_WIDTH = ysyx_22040237_pkg::REG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_rd_i,
  input  logic [REG_WIDTH-1:0] lsu_data_i,
  input  logic                 exu_valid_i,
  output logic                 exu_ready_o,
  input  logic [4:0]           exu_rd_i,
  input  logic [REG_WIDTH-1:0] exu_data_i,
  output logic                 rd_wr_en_o,
  output logic [4:0]           rd_wr_idx_o,
  output logic [REG_WIDTH-1:0] rd_wr_data_o,
  input  logic [4:0]           rs1_idx_i,
  input  logic [4:0]           rs2_idx_i,
  output logic                 rs1_busy_o,
  output logic                 rs2_busy_o,
  output logic                 rs1_hit_o,
  output logic                 rs2_hit_o,
  output logic [REG_WIDTH-1:0] rs1_fwd_o,
  output logic [REG_WIDTH-1:0] rs2_fwd_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head, tail, exu_ptr;
  logic [CNT_W-1:0] count, free;
  wb_entry_t        mem [DEPTH];
  logic             lsu_take, lsu_enq, exu_enq, pop;

  // Free space uses the registered count only; this cycle's pop is not credited.
  assign free        = CNT_W'(DEPTH) - count;
  assign lsu_take    = lsu_valid_i && (lsu_rd_i != '0);
  assign lsu_ready_o = (free != '0);
  assign exu_ready_o = (free > CNT_W'(lsu_take));
  assign lsu_enq     = lsu_take && lsu_ready_o;
  assign exu_enq     = exu_valid_i && exu_ready_o && (exu_rd_i != '0);
  assign pop         = (count != '0);
  assign exu_ptr     = tail + PTR_W'(lsu_enq);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(lsu_enq) + PTR_W'(exu_enq);
      count <= count + CNT_W'(lsu_enq) + CNT_W'(exu_enq) - CNT_W'(pop);
    end
  end

  // LSU result is treated as older and lands at tail when both arrive together.
  always_ff @(posedge clk) begin
    if (lsu_enq) mem[tail]    <= {lsu_rd_i, lsu_data_i};
    if (exu_enq) mem[exu_ptr] <= {exu_rd_i, exu_data_i};
  end

  assign rd_wr_en_o   = pop;
  assign rd_wr_idx_o  = pop ? mem[head].rd   : '0;
  assign rd_wr_data_o = pop ? mem[head].data : '0;

  ysyx_22040237_wb_sb #(.CNT_W(CNT_W)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .inc0_en  (lsu_enq),
    .inc0_idx (lsu_rd_i),
    .inc1_en  (exu_enq),
    .inc1_idx (exu_rd_i),
    .dec_en   (pop),
    .dec_idx  (mem[head].rd),
    .q0_idx   (rs1_idx_i),
    .q1_idx   (rs2_idx_i),
    .q0_busy  (rs1_busy_o),
    .q1_busy  (rs2_busy_o)
  );

`ifdef YSYX_22040237_WB_BYPASS_EN
  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    wb_entry_t        e;
    logic [PTR_W-1:0] p;
    e         = '0;
    p         = '0;
    rs1_hit_o = 1'b0;
    rs2_hit_o = 1'b0;
    rs1_fwd_o = '0;
    rs2_fwd_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        p = head + PTR_W'(i);
        e = mem[p];
        if ((rs1_idx_i != '0) && (e.rd == rs1_idx_i)) begin
          rs1_hit_o = 1'b1;
          rs1_fwd_o = e.data;
        end
        if ((rs2_idx_i != '0) && (e.rd == rs2_idx_i)) begin
          rs2_hit_o = 1'b1;
          rs2_fwd_o = e.data;
        end
      end
    end
  end
`else
  assign rs1_hit_o = 1'b0;
  assign rs2_hit_o = 1'b0;
  assign rs1_fwd_o = '0;
  assign rs2_fwd_o = '0;
`endif
endmodule

// File: tb/tb_ysyx_22040237_wb_queue.sv
// tb/tb_ysyx_22040237_wb_queue.sv - scoreboard bench for the write-back queue
module tb_ysyx_22040237_wb_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lsu_valid_i, exu_valid_i;
  logic        lsu_ready_o, exu_ready_o;
  logic [4:0]  lsu_rd_i, exu_rd_i, rd_wr_idx_o, rs1_idx_i, rs2_idx_i;
  logic [63:0] lsu_data_i, exu_data_i, rd_wr_data_o, rs1_fwd_o, rs2_fwd_o;
  logic        rd_wr_en_o, rs1_busy_o, rs2_busy_o, rs1_hit_o, rs2_hit_o;

  always #5 clk = ~clk;

  ysyx_22040237_wb_queue #(.DEPTH(DEPTH), .REG_WIDTH(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_rd_i     (lsu_rd_i),
    .lsu_data_i   (lsu_data_i),
    .exu_valid_i  (exu_valid_i),
    .exu_ready_o  (exu_ready_o),
    .exu_rd_i     (exu_rd_i),
    .exu_data_i   (exu_data_i),
    .rd_wr_en_o   (rd_wr_en_o),
    .rd_wr_idx_o  (rd_wr_idx_o),
    .rd_wr_data_o (rd_wr_data_o),
    .rs1_idx_i    (rs1_idx_i),
    .rs2_idx_i    (rs2_idx_i),
    .rs1_busy_o   (rs1_busy_o),
    .rs2_busy_o   (rs2_busy_o),
    .rs1_hit_o    (rs1_hit_o),
    .rs2_hit_o    (rs2_hit_o),
    .rs1_fwd_o    (rs1_fwd_o),
    .rs2_fwd_o    (rs2_fwd_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [68:0] exp_q[$];
  int          m_pend[32];
  int          m_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each cycle with a write presented is exactly one retirement of the oldest expected entry.
  always @(negedge clk) begin
    if (rst && rd_wr_en_o) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 64'(rd_wr_idx_o), 64'hffff_ffff);
      end else begin
        logic [68:0] e;
        e = exp_q.pop_front();
        check("wr_idx", 64'(rd_wr_idx_o), 64'(e[68:64]));
        check("wr_data", rd_wr_data_o, e[63:0]);
        m_pend[e[68:64]]--;
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_cnt = 0;
  endtask

  // Called #1 after a rising edge: drives one cycle of stimulus and predicts acceptance.
  task automatic send(input bit lv, input logic [4:0] lr, input logic [63:0] ld,
                      input bit ev, input logic [4:0] er, input logic [63:0] ed);
    bit exp_lr, exp_er, lt;
    int enq;
    lsu_valid_i = lv; lsu_rd_i = lr; lsu_data_i = ld;
    exu_valid_i = ev; exu_rd_i = er; exu_data_i = ed;
    #1;
    lt     = lv && (lr != 5'd0);
    exp_lr = (m_cnt < DEPTH);
    exp_er = ((DEPTH - m_cnt) >= (lt ? 2 : 1));
    check("lsu_ready", 64'(lsu_ready_o), 64'(exp_lr));
    check("exu_ready", 64'(exu_ready_o), 64'(exp_er));
    check("wr_en", 64'(rd_wr_en_o), 64'(m_cnt != 0));
    enq = 0;
    if (lt && exp_lr) begin
      exp_q.push_back({lr, ld}); m_pend[lr]++; enq++;
    end
    if (ev && exp_er && (er != 5'd0)) begin
      exp_q.push_back({er, ed}); m_pend[er]++; enq++;
    end
    @(posedge clk); #1;
    m_cnt = m_cnt + enq - ((m_cnt != 0) ? 1 : 0);
    lsu_valid_i = 1'b0;
    exu_valid_i = 1'b0;
  endtask

  task automatic chk_rs(input logic [4:0] idx);
    bit          h;
    logic [63:0] f;
    h = 1'b0;
    f = '0;
    rs1_idx_i = idx;
    rs2_idx_i = idx;
    #1;
`ifdef YSYX_22040237_WB_BYPASS_EN
    foreach (exp_q[i]) begin
      if ((idx != 5'd0) && (exp_q[i][68:64] == idx)) begin
        h = 1'b1;
        f = exp_q[i][63:0];
      end
    end
`endif
    check("rs1_busy", 64'(rs1_busy_o), 64'((idx != 5'd0) && (m_pend[idx] != 0)));
    check("rs2_busy", 64'(rs2_busy_o), 64'((idx != 5'd0) && (m_pend[idx] != 0)));
    check("rs1_hit", 64'(rs1_hit_o), 64'(h));
    check("rs1_fwd", rs1_fwd_o, f);
    check("rs2_hit", 64'(rs2_hit_o), 64'(h));
    check("rs2_fwd", rs2_fwd_o, f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  initial begin
    clear_model();
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd9;  lsu_data_i = 64'h99;
    exu_valid_i = 1'b1; exu_rd_i = 5'd10; exu_data_i = 64'hAA;
    rs1_idx_i = 5'd9; rs2_idx_i = 5'd10;

    repeat (3) begin
      @(posedge clk); #1;
      check("rst_wr_en", 64'(rd_wr_en_o), 64'd0);
      check("rst_wr_idx", 64'(rd_wr_idx_o), 64'd0);
      check("rst_wr_data", rd_wr_data_o, 64'd0);
      check("rst_busy1", 64'(rs1_busy_o), 64'd0);
      check("rst_busy2", 64'(rs2_busy_o), 64'd0);
      check("rst_hit1", 64'(rs1_hit_o), 64'd0);
      check("rst_lsu_ready", 64'(lsu_ready_o), 64'd1);
      check("rst_exu_ready", 64'(exu_ready_o), 64'd1);
    end
    lsu_valid_i = 1'b0; exu_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    chk_rs(5'd9);

    send(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'h1234);
    chk_rs(5'd5);
    idle(1);
    chk_rs(5'd5);

    send(1'b1, 5'd7, 64'hAA, 1'b1, 5'd7, 64'hBB);
    chk_rs(5'd7);
    idle(1);
    chk_rs(5'd7);
    idle(1);
    chk_rs(5'd7);

    send(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF);
    chk_rs(5'd0);
    idle(1);

    send(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22);
    send(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
    send(1'b1, 5'd5, 64'h55, 1'b1, 5'd6, 64'h66);
    send(1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 64'h66);
    chk_rs(5'd6);
    idle(5);

    send(1'b1, 5'd3, 64'h10, 1'b1, 5'd3, 64'h20);
    chk_rs(5'd3);
    idle(1);
    chk_rs(5'd3);
    idle(2);

    for (int i = 0; i < 60; i++) begin
      send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 64'($urandom),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 64'($urandom));
      chk_rs(5'($urandom_range(0, 7)));
    end

    send(1'b1, 5'd12, 64'hC0, 1'b1, 5'd13, 64'hD0);
    rst = 1'b0;
    #1;
    clear_model();
    check("midrst_wr_en", 64'(rd_wr_en_o), 64'd0);
    chk_rs(5'd12);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    chk_rs(5'd13);

    send(1'b1, 5'd8, 64'h88, 1'b0, 5'd0, 64'd0);
    idle(8);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
